comparator_seq: RTL
===================

// Module: comparator_seq
// PURPOSE
//  Multi-cycle N-bit magnitude comparator: generalises the 1-bit g/l/e comparator to WIDTH bits.
//  Compares CHUNK bits per clock, MSB-first, with early exit on the first differing chunk.
//  Supports unsigned or two's-complement signed operands, selected per operation.
//  Sits behind a start/busy/done handshake; datapath blocks use it where a wide single-cycle compare would not meet timing.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be >= 1
//  CHUNK  2  bits compared per cycle; must be 1..WIDTH with WIDTH % CHUNK == 0
// PORTS
//  clk          in   1      single clock; all state updates on the rising edge
//  rst_n        in   1      reset: asynchronous assertion, active-low
//  start        in   1      request a compare; accepted only when busy==0
//  signed_mode  in   1      1 = two's-complement compare, 0 = unsigned; sampled with start
//  a            in   WIDTH  operand A; sampled with start
//  b            in   WIDTH  operand B; sampled with start
//  busy         out  1      compare in progress; new start is ignored while high
//  done         out  1      one-cycle pulse: g/l/e just updated
//  g            out  1      A > B (latest result)
//  l            out  1      A < B (latest result)
//  e            out  1      A == B (latest result)
// BEHAVIOUR
//  Constants
//  - NCH = WIDTH/CHUNK.
//  - Chunk index k = NCH-1 (MSB chunk) down to 0.
//  Reset (rst_n=0, any time, including mid-operation)
//  - State goes to IDLE; busy=0, done=0, g=0, l=0, e=0; chunk counter and operand registers cleared.
//  FSM states: IDLE, RUN, DONE.
//  - IDLE: start=1 at an edge latches a, b and signed_mode, loads counter=NCH-1, and moves to RUN.
//    With signed_mode=1, bit WIDTH-1 of both latched operands is inverted (sign-bias), so the compare reduces to unsigned.
//  - RUN: each edge compares chunk[counter] of A' against B' as unsigned CHUNK-bit values.
//    * Differ: g=(A'c>B'c), l=~g, e=0; go to DONE.
//    * Equal and counter==0: g=0, l=0, e=1; go to DONE.
//    * Equal and counter>0: decrement counter; stay in RUN.
//  - DONE: lasts exactly one cycle with done=1, then returns to IDLE.
//    start=1 at the DONE edge is accepted exactly as in IDLE (back-to-back operation, no dead cycle).
//  Outputs
//  - busy=1 only in RUN. done=1 only in DONE.
//  - g/l/e are registered; they change only on the edge entering DONE (or on reset).
//    They hold their value through IDLE and the next RUN until the next result.
//  - Exactly one of g/l/e is 1 after the first completed compare; all are 0 only after reset.
//  Latency
//  - Start edge at T0; the first differing chunk is at position j from the MSB (j=1..NCH).
//  - done is high in the cycle after edge T0+j. Equal operands give j=NCH (worst case).
//  - busy is high from after T0 until after T0+j.
//  Boundaries
//  - start while busy=1: ignored; no effect on state or operands; inputs a/b may change freely.
//  - CHUNK==WIDTH: every compare takes one RUN cycle.
//  - WIDTH==1: e=~(a^b), g=a&~b, l=~a&b, matching the 1-bit comparator truth table.
//  - signed_mode applies to the whole operation; mid-operation changes have no effect.
// TESTING (WIDTH=8, CHUNK=2 unless stated)
//  1 a=8'hA5, b=8'hA5, unsigned, start -> busy 4 cycles; done pulse; e=1 g=0 l=0.
//  2 a=8'h80, b=8'h7F: unsigned -> done after 1 RUN cycle, g=1. Same operands signed -> l=1 (-128 < 127).
//  3 a=8'h12, b=8'h13 unsigned -> diff in last chunk, 4 RUN cycles; l=1.
//    Then start at the DONE edge with a=8'hFF, b=8'h00 -> g=1 after 1 RUN cycle.
//  4 start a=8'h00, b=8'h01; pulse start again mid-RUN with a=8'hFF -> ignored; result l=1; no extra done pulse.
//  5 Assert rst_n=0 during RUN of (8'h33, 8'h33), off the clock edge -> busy/done/g/l/e=0 immediately.
//    After release, a fresh compare completes normally.
//  6 Random sweep, WIDTH=1/CHUNK=1 and WIDTH=16/CHUNK=4, both modes -> g/l/e match a golden >,<,== model.
//    Each latency equals the position of the first differing chunk.

Source files
------------

// File: rtl/comparator_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator: walks CHUNK-bit slices MSB-first and
// stops at the first slice that differs. Signed compares are handled by biasing the sign bit.
module comparator_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             l,
    output logic             e
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NSLOT = 1 << CW;

    localparam logic [CW-1:0]    CNT_LAST  = CW'(NCH - 1);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
    localparam logic [WIDTH-1:0] SIGN_BIAS = ONE_W << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             g_q, g_d;
    logic             l_q, l_d;
    logic             e_q, e_d;

    // Slice table padded to a power of two so the counter can index it directly.
    logic [CHUNK-1:0] a_ch [NSLOT];
    logic [CHUNK-1:0] b_ch [NSLOT];
    logic [CHUNK-1:0] a_cur;
    logic [CHUNK-1:0] b_cur;

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slice
        if (gi < NCH) begin : g_real
            assign a_ch[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_ch[gi] = b_q[gi*CHUNK +: CHUNK];
        end else begin : g_pad
            assign a_ch[gi] = '0;
            assign b_ch[gi] = '0;
        end
    end

    assign a_cur = a_ch[cnt_q];
    assign b_cur = b_ch[cnt_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start just like IDLE, so operations can run back-to-back.
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a ^ (signed_mode ? SIGN_BIAS : '0);
                    b_d     = b ^ (signed_mode ? SIGN_BIAS : '0);
                    cnt_d   = CNT_LAST;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (a_cur != b_cur) begin
                    g_d     = (a_cur > b_cur);
                    l_d     = (a_cur < b_cur);
                    e_d     = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == '0) begin
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    e_d     = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign g    = g_q;
    assign l    = l_q;
    assign e    = e_q;

endmodule
